// File: rtl/match_controller.sv
// Match/score controller for the paddle game: tracks per-player scores, serve
// rotation and the winner, sequencing IDLE -> SERVE -> PLAY -> CHECK -> OVER.
module match_controller #(
    parameter int N_PLAYERS       = 2,
    parameter int SCORE_W         = 5,
    parameter int TGT0            = 3,
    parameter int TGT1            = 5,
    parameter int TGT2            = 7,
    parameter int TGT3            = 11,
    parameter int SERVES_PER_TURN = 2,
    parameter int IDXW            = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   max_score,
    input  logic                         win_by_two,
    input  logic                         serve_type,
    input  logic                         serve,
    input  logic                         goal,
    input  logic [IDXW-1:0]              goal_pl,
    output logic [N_PLAYERS*SCORE_W-1:0] scores,
    output logic [IDXW-1:0]              server,
    output logic [IDXW-1:0]              winner,
    output logic                         game_over,
    output logic                         ball_live,
    output logic                         point_pulse,
    output logic [2:0]                   state
);

    localparam int ROTW = (SERVES_PER_TURN > 1) ? $clog2(SERVES_PER_TURN + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_CHECK = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   scores_q [N_PLAYERS];
    logic [IDXW-1:0]      server_q, winner_q, scorer_q;
    logic [ROTW-1:0]      rot_q;
    logic [1:0]           tgt_sel_q;
    logic                 wbt_q, stype_q;

    logic                 goal_ok;
    logic [SCORE_W-1:0]   scorer_score;
    logic                 lead_ok;
    int                   target;
    logic                 win;
    logic [ROTW-1:0]      rot_inc;
    logic                 rotate;

    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
        return (idx == IDXW'(N_PLAYERS - 1)) ? '0 : idx + IDXW'(1);
    endfunction

    assign goal_ok = goal && (int'(goal_pl) < N_PLAYERS);
    assign rot_inc = rot_q + ROTW'(1);
    assign rotate  = (int'(rot_inc) == SERVES_PER_TURN);

    always_comb begin
        scorer_score = '0;
        lead_ok      = 1'b1;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (scorer_q == IDXW'(i)) scorer_score = scores_q[i];
        end
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (scorer_q != IDXW'(i) && int'(scorer_score) < int'(scores_q[i]) + 2) lead_ok = 1'b0;
        end
    end

    always_comb begin
        case (tgt_sel_q)
            2'd0:    target = TGT0;
            2'd1:    target = TGT1;
            2'd2:    target = TGT2;
            default: target = TGT3;
        endcase
    end

    // A saturated counter can never grow its lead, so it ends the match outright.
    assign win = (scorer_score == '1) ||
                 ((int'(scorer_score) >= target) && (!wbt_q || lead_ok));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)   state_d = S_SERVE;
            S_SERVE: if (serve)   state_d = S_PLAY;
            S_PLAY:  if (goal_ok) state_d = S_CHECK;
            S_CHECK: state_d = win ? S_OVER : S_SERVE;
            S_OVER:  if (start)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        state       = state_q;
        game_over   = (state_q == S_OVER);
        ball_live   = (state_q == S_PLAY);
        point_pulse = (state_q == S_CHECK);
        server      = server_q;
        winner      = winner_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_PLAYERS; i++) scores_q[i] <= '0;
            server_q  <= '0;
            winner_q  <= '0;
            scorer_q  <= '0;
            rot_q     <= '0;
            tgt_sel_q <= '0;
            wbt_q     <= 1'b0;
            stype_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    for (int i = 0; i < N_PLAYERS; i++) scores_q[i] <= '0;
                    server_q <= '0;
                    rot_q    <= '0;
                    if (start) begin
                        tgt_sel_q <= max_score;
                        wbt_q     <= win_by_two;
                        stype_q   <= serve_type;
                    end
                end
                S_PLAY: begin
                    if (goal_ok) begin
                        scorer_q <= goal_pl;
                        for (int i = 0; i < N_PLAYERS; i++) begin
                            if (goal_pl == IDXW'(i) && scores_q[i] != '1)
                                scores_q[i] <= scores_q[i] + SCORE_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (win) begin
                        winner_q <= scorer_q;
                    end else if (stype_q) begin
                        server_q <= next_idx(scorer_q);
                    end else if (rotate) begin
                        server_q <= next_idx(server_q);
                        rot_q    <= '0;
                    end else begin
                        rot_q <= rot_inc;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        for (int i = 0; i < N_PLAYERS; i++) scores_q[i] <= '0;
                        server_q <= '0;
                        winner_q <= '0;
                        rot_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_pack
        assign scores[gi*SCORE_W +: SCORE_W] = scores_q[gi];
    end

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: three instances (2 players, 3 players, 2-bit scores)
// share one stimulus bus; each scenario checks the instance it targets.
module tb_match_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, win_by_two = 1'b0, serve_type = 1'b0, serve = 1'b0, goal = 1'b0;
    logic [1:0] max_score = 2'd0, goal_pl = 2'd0;

    logic [9:0]  sc2;  logic srv2, win2, go2, bl2, pp2;  logic [2:0] st2;
    logic [14:0] sc3;  logic [1:0] srv3, win3; logic go3, bl3, pp3; logic [2:0] st3;
    logic [3:0]  scs;  logic srvs, wins, gos, bls, pps;  logic [2:0] sts;

    int n_checks = 0;
    int n_pass = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    match_controller #(.N_PLAYERS(2), .SCORE_W(5)) dut2 (
        .clk(clk), .rst(rst), .start(start), .max_score(max_score), .win_by_two(win_by_two),
        .serve_type(serve_type), .serve(serve), .goal(goal), .goal_pl(goal_pl[0:0]),
        .scores(sc2), .server(srv2), .winner(win2), .game_over(go2), .ball_live(bl2),
        .point_pulse(pp2), .state(st2));

    match_controller #(.N_PLAYERS(3), .SCORE_W(5)) dut3 (
        .clk(clk), .rst(rst), .start(start), .max_score(max_score), .win_by_two(win_by_two),
        .serve_type(serve_type), .serve(serve), .goal(goal), .goal_pl(goal_pl),
        .scores(sc3), .server(srv3), .winner(win3), .game_over(go3), .ball_live(bl3),
        .point_pulse(pp3), .state(st3));

    match_controller #(.N_PLAYERS(2), .SCORE_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .max_score(max_score), .win_by_two(win_by_two),
        .serve_type(serve_type), .serve(serve), .goal(goal), .goal_pl(goal_pl[0:0]),
        .scores(scs), .server(srvs), .winner(wins), .game_over(gos), .ball_live(bls),
        .point_pulse(pps), .state(sts));

    task automatic step();
        @(posedge clk);
        #1;
        if (pp2) pulse_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; serve = 1'b0; goal = 1'b0; goal_pl = 2'd0;
        #1;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic begin_match(input logic [1:0] ms, input logic w, input logic st);
        max_score = ms; win_by_two = w; serve_type = st;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic play_point(input int pl);
        serve = 1'b1;
        step();
        serve = 1'b0;
        goal_pl = 2'(pl);
        goal = 1'b1;
        step();
        goal = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (st2 !== 3'd0) $display("FAIL reset_state: got %0d want 0", st2); else n_pass++;
        n_checks++; if (sc2 !== 10'd0) $display("FAIL reset_scores: got %h want 0", sc2); else n_pass++;
        n_checks++; if ({srv2, win2, go2, bl2, pp2} !== 5'd0)
            $display("FAIL reset_outputs: got %b want 00000", {srv2, win2, go2, bl2, pp2}); else n_pass++;
        begin_match(2'd3, 1'b0, 1'b0);
        play_point(0); play_point(1); play_point(0);
        n_checks++; if (sc2 !== {5'd1, 5'd2}) $display("FAIL pre_reset_scores: got %h want %h", sc2, {5'd1, 5'd2}); else n_pass++;
        serve = 1'b1; step(); serve = 1'b0;
        n_checks++; if (st2 !== 3'd2) $display("FAIL pre_reset_play: got %0d want 2", st2); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (st2 !== 3'd0) $display("FAIL async_reset_state: got %0d want 0", st2); else n_pass++;
        n_checks++; if (sc2 !== 10'd0) $display("FAIL async_reset_scores: got %h want 0", sc2); else n_pass++;
        n_checks++; if ({srv2, win2, go2, bl2, pp2} !== 5'd0)
            $display("FAIL async_reset_outputs: got %b want 00000", {srv2, win2, go2, bl2, pp2}); else n_pass++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_reset();
        begin_match(2'd0, 1'b0, 1'b0);
        pulse_cnt = 0;
        play_point(1);
        n_checks++; if (st2 !== 3'd1) $display("FAIL basic_after1: got %0d want 1", st2); else n_pass++;
        play_point(1); play_point(1);
        n_checks++; if (sc2 !== {5'd3, 5'd0}) $display("FAIL basic_scores: got %h want %h", sc2, {5'd3, 5'd0}); else n_pass++;
        n_checks++; if ({st2, go2, win2} !== {3'd4, 1'b1, 1'b1})
            $display("FAIL basic_over: got st=%0d go=%b win=%b want 4 1 1", st2, go2, win2); else n_pass++;
        n_checks++; if (pulse_cnt !== 3) $display("FAIL basic_pulses: got %0d want 3", pulse_cnt); else n_pass++;
    endtask

    task automatic test_win_by_two();
        do_reset();
        begin_match(2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin play_point(0); play_point(1); end
        n_checks++; if ({st2, sc2} !== {3'd1, 5'd3, 5'd3}) $display("FAIL wbt_3_3: got st=%0d sc=%h want 1 %h", st2, sc2, {5'd3, 5'd3}); else n_pass++;
        play_point(0);
        n_checks++; if ({st2, sc2} !== {3'd1, 5'd3, 5'd4}) $display("FAIL wbt_4_3: got st=%0d sc=%h want 1 %h", st2, sc2, {5'd3, 5'd4}); else n_pass++;
        play_point(0);
        n_checks++; if ({st2, win2, sc2} !== {3'd4, 1'b0, 5'd3, 5'd5})
            $display("FAIL wbt_5_3: got st=%0d win=%b sc=%h want 4 0 %h", st2, win2, sc2, {5'd3, 5'd5}); else n_pass++;
    endtask

    task automatic test_rotation();
        logic exp_srv [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        begin_match(2'd3, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (srv2 !== exp_srv[k]) $display("FAIL rot_type0_%0d: got %b want %b", k, srv2, exp_srv[k]); else n_pass++;
            if (k < 4) play_point(int'($urandom_range(0, 1)));
        end
        do_reset();
        begin_match(2'd3, 1'b0, 1'b1);
        play_point(1);
        n_checks++; if (srv2 !== 1'b0) $display("FAIL rot_type1_p1: got %b want 0", srv2); else n_pass++;
        play_point(0);
        n_checks++; if (srv2 !== 1'b1) $display("FAIL rot_type1_p0: got %b want 1", srv2); else n_pass++;
    endtask

    task automatic test_ignored();
        do_reset();
        begin_match(2'd0, 1'b0, 1'b0);
        goal_pl = 2'd1; goal = 1'b1; step(); goal = 1'b0;
        n_checks++; if ({st2, sc2} !== {3'd1, 10'd0}) $display("FAIL ign_goal_serve: got st=%0d sc=%h want 1 0", st2, sc2); else n_pass++;
        serve = 1'b1; goal = 1'b1; step(); serve = 1'b0; goal = 1'b0;
        n_checks++; if ({st2, sc2} !== {3'd2, 10'd0}) $display("FAIL ign_goal_with_serve: got st=%0d sc=%h want 2 0", st2, sc2); else n_pass++;
        serve = 1'b1; step(); serve = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if (st2 !== 3'd2) $display("FAIL ign_serve_start_play: got %0d want 2", st2); else n_pass++;
        max_score = 2'd3; win_by_two = 1'b1; serve_type = 1'b1;
        goal_pl = 2'd0; goal = 1'b1; step(); goal = 1'b0; step();
        n_checks++; if (srv2 !== 1'b0) $display("FAIL ign_serve_type: got %b want 0", srv2); else n_pass++;
        play_point(0); play_point(0);
        n_checks++; if ({st2, win2, sc2} !== {3'd4, 1'b0, 5'd0, 5'd3})
            $display("FAIL ign_target_latched: got st=%0d win=%b sc=%h want 4 0 %h", st2, win2, sc2, {5'd0, 5'd3}); else n_pass++;
        goal_pl = 2'd1; goal = 1'b1; serve = 1'b1; step(); goal = 1'b0; serve = 1'b0; step();
        n_checks++; if ({st2, sc2} !== {3'd4, 5'd0, 5'd3}) $display("FAIL ign_over_frozen: got st=%0d sc=%h", st2, sc2); else n_pass++;
        do_reset();
        begin_match(2'd0, 1'b0, 1'b0);
        serve = 1'b1; step(); serve = 1'b0;
        goal_pl = 2'd3; goal = 1'b1; step(); goal = 1'b0;
        n_checks++; if ({st3, sc3} !== {3'd2, 15'd0}) $display("FAIL ign_bad_player: got st=%0d sc=%h want 2 0", st3, sc3); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        begin_match(2'd3, 1'b1, 1'b0);
        play_point(1); play_point(1); play_point(0); play_point(0);
        n_checks++; if ({sts, scs} !== {3'd1, 2'd2, 2'd2}) $display("FAIL sat_2_2: got st=%0d sc=%h", sts, scs); else n_pass++;
        play_point(0);
        n_checks++; if ({sts, wins, scs} !== {3'd4, 1'b0, 2'd2, 2'd3})
            $display("FAIL sat_win: got st=%0d win=%b sc=%h want 4 0 b", sts, wins, scs); else n_pass++;
        start = 1'b1; step(); start = 1'b0;
        n_checks++; if ({sts, scs, gos} !== {3'd0, 4'd0, 1'b0})
            $display("FAIL sat_restart: got st=%0d sc=%h go=%b want 0 0 0", sts, scs, gos); else n_pass++;
    endtask

    task automatic test_random();
        int sc [3];
        int npts, srv, tgt, pl, s;
        bit over, lead;
        logic [1:0] ms;
        logic w, st;
        logic [14:0] exp_sc;
        do_reset();
        for (int m = 0; m < 8; m++) begin
            ms = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            tgt = (ms == 2'd0) ? 3 : (ms == 2'd1) ? 5 : (ms == 2'd2) ? 7 : 11;
            for (int i = 0; i < 3; i++) sc[i] = 0;
            npts = 0; srv = 0; over = 1'b0;
            begin_match(ms, w, st);
            for (int k = 0; k < 80 && !over; k++) begin
                pl = int'($urandom_range(0, 2));
                max_score = 2'($urandom_range(0, 3));
                win_by_two = 1'($urandom_range(0, 1));
                serve_type = 1'($urandom_range(0, 1));
                serve = 1'b1; step(); serve = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    goal_pl = 2'd3; goal = 1'b1; step(); goal = 1'b0;
                    n_checks++; if (st3 !== 3'd2) $display("FAIL rnd_bad_goal m%0d: got %0d want 2", m, st3); else n_pass++;
                end
                goal_pl = 2'(pl); goal = 1'b1; step(); goal = 1'b0;
                if (sc[pl] < 31) sc[pl]++;
                npts++;
                for (int i = 0; i < 3; i++) exp_sc[i*5 +: 5] = 5'(sc[i]);
                n_checks++; if ({pp3, sc3} !== {1'b1, exp_sc})
                    $display("FAIL rnd_score m%0d: got pp=%b sc=%h want 1 %h", m, pp3, sc3, exp_sc); else n_pass++;
                s = sc[pl];
                lead = 1'b1;
                for (int i = 0; i < 3; i++) if (i != pl && s < sc[i] + 2) lead = 1'b0;
                over = (s == 31) || (s >= tgt && (!w || lead));
                if (!over) srv = st ? (pl + 1) % 3 : (npts / 2) % 3;
                step();
                n_checks++; if ({st3, srv3} !== {(over ? 3'd4 : 3'd1), 2'(srv)})
                    $display("FAIL rnd_next m%0d: got st=%0d srv=%0d want %0d %0d", m, st3, srv3, over ? 4 : 1, srv); else n_pass++;
                if (over) begin
                    n_checks++; if ({go3, win3} !== {1'b1, 2'(pl)}) $display("FAIL rnd_winner m%0d: got %0d want %0d", m, win3, pl); else n_pass++;
                end
                $display("match %0d point %0d: scorer=%0d scores=%0d:%0d:%0d server=%0d over=%0d", m, k, pl, sc[0], sc[1], sc[2], srv, over);
            end
            if (over) begin
                start = 1'b1; step(); start = 1'b0;
                n_checks++; if ({st3, sc3, srv3, win3} !== 22'd0)
                    $display("FAIL rnd_restart m%0d: got st=%0d sc=%h srv=%0d win=%0d", m, st3, sc3, srv3, win3); else n_pass++;
            end else begin
                do_reset();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_win_by_two();
        test_rotation();
        test_ignored();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
